rgb_pwm_driver: RTL and testbench
=================================

// Module: rgb_pwm_driver
// PURPOSE
//  Consumes the 8-bit r/g/b levels produced by the control unit and drives three LED PWM pins.
//  - Double-buffered: new levels are accepted via a load handshake.
//  - New levels take effect only at a PWM period boundary, so there is no glitching mid-period.
//  - Optional slew limiting gives hardware-smooth fades.
//  - Sits between the control unit and the board LED pins.
// PARAMETERS
//  W          8   level width; PWM period = 2^W-1 ticks (255)
//  PRESCALE   4   clk cycles per PWM tick (>=1)
//  SLEW_STEP  0   max duty change per period; 0 = jump straight to target
//  ACTIVE_LOW 0   1 = pins are active-low (inactive level 1)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  on           in   1  master enable; 0 forces pins inactive
//  r            in   W  red level to load
//  g            in   W  green level to load
//  b            in   W  blue level to load
//  load         in   1  valid: capture r/g/b when load_ready=1
//  load_ready   out  1  pending buffer empty; load will be accepted
//  pwm_r        out  1  red PWM pin (registered)
//  pwm_g        out  1  green PWM pin (registered)
//  pwm_b        out  1  blue PWM pin (registered)
//  period_start out  1  1-cycle pulse, first cycle of each PWM period
//  busy         out  1  any channel's duty != its target (slew in progress)
// BEHAVIOUR
//  - Reset: all counters, pending, target and duty regs = 0; pending_valid=0.
//    Outputs: load_ready=1, pwm_*=inactive level, period_start=0, busy=0.
//    Reset asserted mid-operation gives these values on the next edge; an in-flight ramp is discarded.
//  - Prescaler: pre counts 0..PRESCALE-1 and wraps; tick = (pre==PRESCALE-1).
//  - PWM counter: cnt 0..2^W-2, advances on tick.
//  - Boundary event B = tick && cnt==2^W-2. On B:
//      cnt<=0; period_start<=1 for one cycle.
//      If pending_valid: target<=pending, pending_valid<=0.
//      Duty then updates from the new target.
//  - Duty update at B:
//      SLEW_STEP==0: duty<=target.
//      Else: duty moves toward target by min(SLEW_STEP, |target-duty|).
//      Unsigned compare, saturating; never overshoots or wraps.
//  - Pin: pwm_x <= on && (cnt < duty_x), XOR ACTIVE_LOW; 1-cycle latency from cnt/duty.
//    duty=0 gives never active; duty=255 gives always active (255 of 255 ticks).
//  - Handshake:
//      load_ready = !pending_valid.
//      load && load_ready: pending<=r,g,b; pending_valid<=1.
//      load while !load_ready is ignored and dropped, never queued.
//  - Load in the same cycle as B with buffer empty: captured into pending and applied at the NEXT B.
//    With buffer full, B consumes the old pending and load_ready rises in the cycle after B.
//  - busy is registered: 1 while any duty_x != target_x, evaluated after each update.
//  - on=0: pins go inactive next cycle. Counters, duty and handshake keep running.
//    on=1 resumes on the next cycle with no reload.
// STRUCTURE
//  - Package rgb_pkg: localparam W, PWM_MAX=2^W-2, typedef rgb_t {r,g,b} of W bits,
//    function slew_step(cur,tgt,step).
//  - Sub-module pwm_channel, instantiated x3: target/duty regs, slew logic, compare, pin reg.
//  - Top holds prescaler, cnt, B detect, pending buffer and handshake.
// TESTING (bench uses PRESCALE=1)
//  1. Reset, load r=0 g=255 b=128; then count each pin's active cycles over the full period after B.
//     Required: r=0, g=255, b=128 of 255.
//  2. Load A: load_ready falls next cycle. Load B while busy: dropped.
//     Required: A is applied at B and load_ready=1 the cycle after.
//  3. SLEW_STEP=16, duty 0, target 100.
//     Required: successive periods show duty 16,32,48,64,80,96,100; busy falls after 100.
//  4. on=0 at cnt=50 with duty=200: pins inactive next cycle.
//     Then on=1 at cnt=100: pins active next cycle, no reload needed.
//  5. rst pulsed mid-ramp at duty=48: next cycle all outputs at reset values.
//     Required: load_ready=1, duty restarts from 0.
//  6. Load 77 in the exact cycle of B: period_start period uses the old duty.
//     Required: 77 appears from the following period; ACTIVE_LOW=1 gives inverted pins.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared width, PWM period limit, RGB record and the per-period slew helper
// used by the RGB LED PWM driver and its channels.
package rgb_pkg;

    localparam int W = 8;
    localparam logic [W-1:0] PWM_MAX = W'((1 << W) - 2);

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
    } rgb_t;

    // One boundary's worth of movement from cur toward tgt; never overshoots.
    function automatic logic [W-1:0] slew_step(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt,
                                               input int unsigned  step);
        logic [W-1:0] diff;
        if (step == 0) begin
            return tgt;
        end
        if (tgt >= cur) begin
            diff = tgt - cur;
            return (32'(diff) > step) ? cur + W'(step) : tgt;
        end
        diff = cur - tgt;
        return (32'(diff) > step) ? cur - W'(step) : tgt;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED colour: target and duty registers, slew toward target at each period
// boundary, and a registered compare against the shared period counter.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter int SLEW_STEP  = 0,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         on,
    input  logic         boundary,
    input  logic         apply,
    input  logic [W-1:0] pend,
    input  logic [W-1:0] cnt,
    output logic         pin,
    output logic         ramp_next
);

    logic [W-1:0] target_q;
    logic [W-1:0] duty_q;
    logic [W-1:0] target_d;
    logic [W-1:0] duty_d;

    // Duty steps from the freshly applied target, not the one being replaced.
    always_comb begin
        target_d = target_q;
        duty_d   = duty_q;
        if (boundary) begin
            if (apply) begin
                target_d = pend;
            end
            duty_d = slew_step(duty_q, target_d, SLEW_STEP);
        end
    end

    assign ramp_next = (duty_d != target_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
            duty_q   <= '0;
            pin      <= ACTIVE_LOW;
        end else begin
            target_q <= target_d;
            duty_q   <= duty_d;
            pin      <= (on && (cnt < duty_q)) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver with a double-buffered level load; new levels
// take effect only at a period boundary, optionally slew-limited.
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int PRESCALE   = 4,
    parameter int SLEW_STEP  = 0,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         on,
    input  logic [W-1:0] r,
    input  logic [W-1:0] g,
    input  logic [W-1:0] b,
    input  logic         load,
    output logic         load_ready,
    output logic         pwm_r,
    output logic         pwm_g,
    output logic         pwm_b,
    output logic         period_start,
    output logic         busy
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_q;
    logic [W-1:0]     cnt_q;
    logic             tick;
    logic             bnd;
    rgb_t             pending_q;
    logic             pending_valid;
    logic             apply;
    logic             ramp_r;
    logic             ramp_g;
    logic             ramp_b;

    assign tick  = (pre_q == PRE_W'(PRESCALE - 1));
    assign bnd   = tick && (cnt_q == PWM_MAX);
    assign apply = bnd && pending_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            cnt_q        <= '0;
            period_start <= 1'b0;
        end else begin
            pre_q        <= tick ? '0 : pre_q + PRE_W'(1);
            period_start <= bnd;
            if (tick) begin
                cnt_q <= bnd ? '0 : cnt_q + W'(1);
            end
        end
    end

    // Load handshake: load is valid, load_ready is ready; a transfer happens on
    // a clock edge where both are 1. load while not ready is dropped, not held.
    // The buffer drains only at a boundary, so load_ready reopens after it.
    assign load_ready = !pending_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= '0;
            pending_valid <= 1'b0;
        end else if (apply) begin
            pending_valid <= 1'b0;
        end else if (load && load_ready) begin
            pending_q     <= '{r: r, g: g, b: b};
            pending_valid <= 1'b1;
        end
    end

    pwm_channel #(.SLEW_STEP(SLEW_STEP), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
        .clk(clk), .rst(rst), .on(on), .boundary(bnd), .apply(apply),
        .pend(pending_q.r), .cnt(cnt_q), .pin(pwm_r), .ramp_next(ramp_r)
    );

    pwm_channel #(.SLEW_STEP(SLEW_STEP), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
        .clk(clk), .rst(rst), .on(on), .boundary(bnd), .apply(apply),
        .pend(pending_q.g), .cnt(cnt_q), .pin(pwm_g), .ramp_next(ramp_g)
    );

    pwm_channel #(.SLEW_STEP(SLEW_STEP), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
        .clk(clk), .rst(rst), .on(on), .boundary(bnd), .apply(apply),
        .pend(pending_q.b), .cnt(cnt_q), .pin(pwm_b), .ramp_next(ramp_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= ramp_r || ramp_g || ramp_b;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: three instances (plain, slew 16, active-low) share
// one stimulus stream; outputs are sampled on the falling edge.
module tb_rgb_pwm_driver;
    import rgb_pkg::*;

    logic clk;
    logic rst;
    logic on;
    logic [W-1:0] r, g, b;
    logic load;

    logic lr0, pwm_r0, pwm_g0, pwm_b0, ps0, busy0;
    logic lrs, pwm_rs, pwm_gs, pwm_bs, pss, busys;
    logic lral, pwm_ral, pwm_gal, pwm_bal, psal, busyal;

    int n_vec;
    int n_bad;
    int c0[3];
    int cs[3];
    int cal[3];

    typedef struct {
        logic [W-1:0] r, g, b;
        int er, eg, eb;
        int sr, sg, sb;
    } vec_t;
    vec_t vecs[4];

    int slew_exp_r[7];
    int slew_exp_b[7];

    rgb_pwm_driver #(.PRESCALE(1), .SLEW_STEP(0), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .on(on), .r(r), .g(g), .b(b), .load(load),
        .load_ready(lr0), .pwm_r(pwm_r0), .pwm_g(pwm_g0), .pwm_b(pwm_b0),
        .period_start(ps0), .busy(busy0)
    );

    rgb_pwm_driver #(.PRESCALE(1), .SLEW_STEP(16), .ACTIVE_LOW(1'b0)) dut_s (
        .clk(clk), .rst(rst), .on(on), .r(r), .g(g), .b(b), .load(load),
        .load_ready(lrs), .pwm_r(pwm_rs), .pwm_g(pwm_gs), .pwm_b(pwm_bs),
        .period_start(pss), .busy(busys)
    );

    rgb_pwm_driver #(.PRESCALE(1), .SLEW_STEP(0), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .on(on), .r(r), .g(g), .b(b), .load(load),
        .load_ready(lral), .pwm_r(pwm_ral), .pwm_g(pwm_gal), .pwm_b(pwm_bal),
        .period_start(psal), .busy(busyal)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_load_ready", int'({lr0, lrs, lral}), 7);
        check("rst_pins_plain", int'({pwm_r0, pwm_g0, pwm_b0, pwm_rs, pwm_gs, pwm_bs}), 0);
        check("rst_pins_al", int'({pwm_ral, pwm_gal, pwm_bal}), 7);
        check("rst_period_start", int'({ps0, pss, psal}), 0);
        check("rst_busy", int'({busy0, busys, busyal}), 0);
        rst = 1'b0;
    endtask

    // driver: called at a falling edge; holds load for one rising edge
    task automatic do_load(input logic [W-1:0] vr, input logic [W-1:0] vg,
                           input logic [W-1:0] vb);
        r = vr;
        g = vg;
        b = vb;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ps(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (ps0) got = 1'b1;
        end
        check(name, int'(got), 1);
    endtask

    // Called in a period_start cycle; returns in the next period_start cycle.
    task automatic measure();
        int ps_seen;
        ps_seen = 0;
        for (int k = 0; k < 3; k++) begin
            c0[k] = 0;
            cs[k] = 0;
            cal[k] = 0;
        end
        repeat (255) begin
            @(negedge clk);
            c0[0] += int'(pwm_r0);
            c0[1] += int'(pwm_g0);
            c0[2] += int'(pwm_b0);
            cs[0] += int'(pwm_rs);
            cs[1] += int'(pwm_gs);
            cs[2] += int'(pwm_bs);
            cal[0] += int'(!pwm_ral);
            cal[1] += int'(!pwm_gal);
            cal[2] += int'(!pwm_bal);
            if (ps0) ps_seen++;
        end
        check("ps_once_per_period", ps_seen, 1);
        check("ps_at_period_end", int'(ps0), 1);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        on = 1'b1;
        load = 1'b0;
        r = '0;
        g = '0;
        b = '0;

        vecs[0] = '{r: 8'd0,   g: 8'd255, b: 8'd128, er: 0,   eg: 255, eb: 128, sr: 0,  sg: 16, sb: 16};
        vecs[1] = '{r: 8'd1,   g: 8'd254, b: 8'd2,   er: 1,   eg: 254, eb: 2,   sr: 1,  sg: 16, sb: 2};
        vecs[2] = '{r: 8'd100, g: 8'd50,  b: 8'd200, er: 100, eg: 50,  eb: 200, sr: 16, sg: 16, sb: 16};
        vecs[3] = '{r: 8'd255, g: 8'd0,   b: 8'd1,   er: 255, eg: 0,   eb: 1,   sr: 16, sg: 0,  sb: 1};
        slew_exp_r = '{16, 32, 48, 64, 80, 96, 100};
        slew_exp_b = '{16, 32, 40, 40, 40, 40, 40};

        // levels applied at the first boundary, one full period counted
        foreach (vecs[i]) begin
            do_reset();
            do_load(vecs[i].r, vecs[i].g, vecs[i].b);
            wait_ps("v_first_boundary");
            measure();
            check("v_r_plain", c0[0], vecs[i].er);
            check("v_g_plain", c0[1], vecs[i].eg);
            check("v_b_plain", c0[2], vecs[i].eb);
            check("v_r_al", cal[0], vecs[i].er);
            check("v_g_al", cal[1], vecs[i].eg);
            check("v_b_al", cal[2], vecs[i].eb);
            check("v_r_slew", cs[0], vecs[i].sr);
            check("v_g_slew", cs[1], vecs[i].sg);
            check("v_b_slew", cs[2], vecs[i].sb);
            check("v_busy_plain", int'(busy0), 0);
        end

        // second load while buffer full is dropped
        do_reset();
        do_load(8'd10, 8'd20, 8'd30);
        check("hs_ready_low_after_load", int'(lr0), 0);
        do_load(8'd200, 8'd200, 8'd200);
        check("hs_ready_still_low", int'(lr0), 0);
        wait_ps("hs_boundary");
        check("hs_ready_after_boundary", int'(lr0), 1);
        measure();
        check("hs_r", c0[0], 10);
        check("hs_g", c0[1], 20);
        check("hs_b", c0[2], 30);
        measure();
        check("hs_dropped_r", c0[0], 10);
        check("hs_dropped_b", c0[2], 30);

        // slew ramp 0 -> 100 in steps of 16
        do_reset();
        do_load(8'd100, 8'd0, 8'd40);
        wait_ps("slew_boundary");
        for (int k = 0; k < 7; k++) begin
            check("slew_busy", int'(busys), int'(slew_exp_r[k] != 100));
            measure();
            check("slew_r", cs[0], slew_exp_r[k]);
            check("slew_g", cs[1], 0);
            check("slew_b", cs[2], slew_exp_b[k]);
        end
        check("slew_busy_done", int'(busys), 0);
        measure();
        check("slew_r_settled", cs[0], 100);

        // master enable off at cnt=50, on again at cnt=100
        do_reset();
        do_load(8'd200, 8'd200, 8'd200);
        wait_ps("on_boundary");
        repeat (50) @(negedge clk);
        check("on_pins_before", int'({pwm_r0, pwm_g0, pwm_b0}), 7);
        on = 1'b0;
        @(negedge clk);
        check("off_pins_plain", int'({pwm_r0, pwm_g0, pwm_b0}), 0);
        check("off_pins_al", int'({pwm_ral, pwm_gal, pwm_bal}), 7);
        begin
            int act_cnt;
            act_cnt = 0;
            repeat (49) begin
                @(negedge clk);
                act_cnt += int'(pwm_r0 | pwm_g0 | pwm_b0);
            end
            check("off_window_active", act_cnt, 0);
        end
        on = 1'b1;
        @(negedge clk);
        check("on_pins_plain", int'({pwm_r0, pwm_g0, pwm_b0}), 7);
        check("on_pins_al", int'({pwm_ral, pwm_gal, pwm_bal}), 0);
        repeat (153) @(negedge clk);
        check("on_counter_ps_early", int'(ps0), 0);
        @(negedge clk);
        check("on_counter_ps_kept", int'(ps0), 1);

        // reset during a ramp at duty 48
        do_reset();
        do_load(8'd100, 8'd100, 8'd100);
        wait_ps("rr_boundary");
        measure();
        measure();
        check("rr_duty32", cs[0], 32);
        repeat (10) @(negedge clk);
        check("rr_pin_active", int'(pwm_rs), 1);
        do_load(8'd5, 8'd5, 8'd5);
        check("rr_ready_low", int'(lrs), 0);
        do_reset();
        do_load(8'd100, 8'd100, 8'd100);
        wait_ps("rr_boundary2");
        measure();
        check("rr_restart_r", cs[0], 16);
        check("rr_restart_g", cs[1], 16);

        // load exactly on the boundary cycle
        do_reset();
        do_load(8'd30, 8'd30, 8'd30);
        wait_ps("lb_boundary");
        measure();
        check("lb_old_plain", c0[0], 30);
        repeat (254) @(negedge clk);
        check("lb_not_ps_yet", int'(ps0), 0);
        do_load(8'd77, 8'd77, 8'd77);
        check("lb_ps_now", int'(ps0), 1);
        check("lb_captured", int'(lr0), 0);
        measure();
        check("lb_period_old_plain", c0[0], 30);
        check("lb_period_old_al", cal[1], 30);
        check("lb_ready_back", int'(lr0), 1);
        measure();
        check("lb_new_plain", c0[2], 77);
        check("lb_new_al_r", cal[0], 77);
        check("lb_new_al_b", cal[2], 77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
